button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Front end for the three Connect-Four push-buttons, upstream of the game top.
//  Synchronises and debounces the raw right/left/enter buttons. Emits single-cycle
//  pulses on the game's right/left/enter inputs.
//  Adds auto-repeat on right/left, resolves conflicts between buttons, and gates
//  all moves while the freeze input is high.
// PARAMETERS
//  DB_CYCLES   1_000_000   consecutive stable cycles required to accept a level change (>=2)
//  RPT_DELAY   40_000_000  cycles from a right/left press pulse to its first repeat pulse (>=2)
//  RPT_PERIOD  15_000_000  cycles between later repeat pulses (>=2)
//  CNT_W       26          counter width; must hold max(DB_CYCLES,RPT_DELAY,RPT_PERIOD)
// PORTS
//  clk        in   1  system clock, one domain
//  reset      in   1  asynchronous, active-low; all flops cleared while low
//  right_raw  in   1  raw button, active-high, asynchronous to clk
//  left_raw   in   1  raw button, active-high, asynchronous to clk
//  enter_raw  in   1  raw button, active-high, asynchronous to clk
//  freeze     in   1  high = suppress all output pulses (driven from win != 0)
//  right      out  1  one-cycle move-right pulse, registered
//  left       out  1  one-cycle move-left pulse, registered
//  enter      out  1  one-cycle drop-piece pulse, registered
// BEHAVIOUR
//  Reset: sync flops, stable levels, counters and outputs = 0; repeat FSMs = IDLE.
//  Sync: each raw input passes through 2 flops before any use.
//  Debounce (per channel):
//   - cnt increments each cycle that sync_out != stable; cnt clears when they are equal.
//   - When cnt == DB_CYCLES-1 and they still differ: stable flips and cnt clears.
//   - press = 1 in the same cycle stable goes 0->1.
//  Latency: raw first sampled 1 at edge N and held -> press high for the single cycle
//   after edge N+DB_CYCLES+1. A bounce shorter than DB_CYCLES produces no pulse.
//  Repeat FSM (right/left only; enter never repeats):
//   - IDLE -press-> DELAY (tmr=0).
//   - DELAY: tmr==RPT_DELAY-1 -> rpt pulse, go REPEAT (tmr=0).
//   - REPEAT: tmr==RPT_PERIOD-1 -> rpt pulse, tmr=0.
//   - Any state: stable==0 -> IDLE in the next cycle.
//   - Channel request = press | rpt.
//  Arbitration (registered into outputs, one cycle after the request):
//   - right and left requests in the same cycle: both dropped.
//   - enter request coincident with a right/left request: enter wins; right/left dropped.
//   - While right and left are both stable high: both FSMs are held in IDLE.
//  freeze=1: outputs forced 0 and repeat FSMs held in IDLE. Debounce keeps tracking.
//   A press whose pulse falls inside freeze is lost, not deferred.
//  Button held through reset release: exactly one press after debounce, since stable restarts at 0.
//  Reset mid-count or mid-repeat: pulse is cancelled immediately (async); no partial output.
//  Outputs are never high for two consecutive cycles.
// STRUCTURE
//  Shared package conn4_pkg:
//   - default DB_CYCLES/RPT_DELAY/RPT_PERIOD constants.
//   - repeat-state encoding: IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2.
//  Sub-module btn_debounce (2-flop sync + counter + stable + press), instantiated 3x.
//  Repeat FSMs, arbitration and output registers live in this module.
// TESTING (bench uses DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8)
//  1 Clean enter press held 50 cycles -> enter high exactly 1 cycle, 6 cycles after first
//    sampling edge; no further pulses.
//  2 right_raw toggles every 2 cycles for 20 cycles, then held 1 -> only one right pulse,
//    6 cycles after the hold starts.
//  3 left held 60 cycles after accept -> pulses at press, +20, +28, +36, +44, +52;
//    release -> no further pulses.
//  4 right and left accepted the same cycle -> no output. enter+right same cycle -> enter only.
//  5 freeze=1 while pressing enter -> no pulse. freeze drops with button still held ->
//    no late pulse. Fresh press after that -> normal pulse.
//  6 reset low for 3 cycles during REPEAT with left held -> outputs 0 immediately;
//    after release exactly one left pulse at DB_CYCLES+2, then repeats restart from RPT_DELAY.

Source files
------------

// File: rtl/conn4_pkg.sv
// rtl/conn4_pkg.sv - shared Connect-Four button constants, repeat-state encoding and arbitration
package conn4_pkg;

  localparam int DB_CYCLES_DEF  = 1_000_000;
  localparam int RPT_DELAY_DEF  = 40_000_000;
  localparam int RPT_PERIOD_DEF = 15_000_000;
  localparam int CNT_W_DEF      = 26;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  typedef struct packed {
    logic right;
    logic left;
    logic enter;
  } move_t;

  // Opposite moves cancel each other; a drop always beats a sideways move.
  function automatic move_t arbitrate(input logic req_right, input logic req_left,
                                      input logic req_enter, input logic frz);
    move_t m;
    m = '0;
    if (!frz) begin
      m.enter = req_enter;
      m.right = req_right && !req_left && !req_enter;
      m.left  = req_left && !req_right && !req_enter;
    end
    return m;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button inputs and conditioned move pulses
interface button_conditioner_if;

  logic right_raw;
  logic left_raw;
  logic enter_raw;
  logic freeze;
  logic right;
  logic left;
  logic enter;

  modport master (
    output right_raw, left_raw, enter_raw, freeze,
    input  right, left, enter
  );

  modport slave (
    input  right_raw, left_raw, enter_raw, freeze,
    output right, left, enter
  );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus stability counter for one push-button
module btn_debounce
  import conn4_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      // Any cycle of agreement restarts the count, so bounces never accumulate.
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        stable <= sync_2;
        press  <= sync_2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced, auto-repeating, arbitrated Connect-Four button front end
module button_conditioner
  import conn4_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave btn
);

  // Index 0 is the right channel, index 1 the left channel.
  logic [1:0]            stable_mv;
  logic [1:0]            press_mv;
  logic [1:0]            rpt;
  logic [1:0]            req_mv;
  logic                  press_enter;
  logic                  unused_enter_stable;
  logic                  hold_idle;
  rpt_state_t [1:0]      state_q;
  rpt_state_t [1:0]      state_d;
  logic [1:0][CNT_W-1:0] tmr_q;
  logic [1:0][CNT_W-1:0] tmr_d;
  move_t                 move_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_right (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn.right_raw),
    .stable (stable_mv[0]),
    .press  (press_mv[0])
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_left (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn.left_raw),
    .stable (stable_mv[1]),
    .press  (press_mv[1])
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_enter (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn.enter_raw),
    .stable (unused_enter_stable),
    .press  (press_enter)
  );

  // Holding both directions at once is treated as "no direction".
  assign hold_idle = btn.freeze || (stable_mv == 2'b11);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q[0] <= IDLE;
      state_q[1] <= IDLE;
      tmr_q      <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rpt     = '0;
    for (int i = 0; i < 2; i++) begin
      if (!stable_mv[i] || hold_idle) begin
        state_d[i] = IDLE;
        tmr_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            tmr_d[i] = '0;
            if (press_mv[i]) state_d[i] = DELAY;
          end
          DELAY: begin
            if (tmr_q[i] == CNT_W'(RPT_DELAY - 1)) begin
              rpt[i]     = 1'b1;
              state_d[i] = REPEAT;
              tmr_d[i]   = '0;
            end else begin
              tmr_d[i] = tmr_q[i] + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (tmr_q[i] == CNT_W'(RPT_PERIOD - 1)) begin
              rpt[i]   = 1'b1;
              tmr_d[i] = '0;
            end else begin
              tmr_d[i] = tmr_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = IDLE;
            tmr_d[i]   = '0;
          end
        endcase
      end
    end
  end

  assign req_mv = press_mv | rpt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      move_q <= '0;
    end else begin
      move_q <= arbitrate(req_mv[0], req_mv[1], press_enter, btn.freeze);
    end
  end

  assign btn.right = move_q.right;
  assign btn.left  = move_q.left;
  assign btn.enter = move_q.enter;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - vector table and scoreboard bench for button_conditioner
module tb_button_conditioner;

  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int CW  = 8;
  // Cycle of the input drive to the edge that raises the output pulse.
  localparam int LAT = DB + 3;

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } exp_t;

  typedef struct {
    logic [2:0] btns;
    logic       frz;
    int         hold;
    logic [2:0] first;
    int         n_rpt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_conditioner_if bi();

  button_conditioner #(
    .DB_CYCLES  (DB),
    .RPT_DELAY  (RD),
    .RPT_PERIOD (RP),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bi.slave)
  );

  function automatic logic [2:0] outs();
    return {bi.right, bi.left, bi.enter};
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got {r,l,e}=%b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] v);
    exp_t x;
    x.cyc = c;
    x.val = v;
    exp_q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btns(input logic [2:0] b);
    bi.right_raw = b[2];
    bi.left_raw  = b[1];
    bi.enter_raw = b[0];
  endtask

  task automatic expect_press(input int k, input logic [2:0] v, input int n_rpt);
    if (v != 3'b000) push(k + LAT, v);
    for (int j = 0; j < n_rpt; j++) push(k + LAT + RD + j * RP, v);
  endtask

  always @(negedge clk) begin : monitor
    logic [2:0] e;
    e = 3'b000;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q[0].val;
      void'(exp_q.pop_front());
    end
    check("pulse_stream", outs(), e);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   k;
    int   m;
    vecs[0] = '{3'b001, 1'b0, 50, 3'b001, 0};
    vecs[1] = '{3'b010, 1'b0, 60, 3'b010, 5};
    vecs[2] = '{3'b110, 1'b0, 40, 3'b000, 0};
    vecs[3] = '{3'b101, 1'b0, 10, 3'b001, 0};
    vecs[4] = '{3'b001, 1'b1, 20, 3'b000, 0};
    vecs[5] = '{3'b100, 1'b0, 10, 3'b100, 0};
    vecs[6] = '{3'b100, 1'b0, 30, 3'b100, 2};

    set_btns(3'b000);
    bi.freeze = 1'b0;
    reset = 1'b0;
    tick(3);
    check("reset_outputs", outs(), 3'b000);
    reset = 1'b1;
    tick(5);

    for (int i = 0; i < 7; i++) begin
      bi.freeze = vecs[i].frz;
      set_btns(vecs[i].btns);
      expect_press(cyc, vecs[i].first, vecs[i].n_rpt);
      tick(vecs[i].hold);
      set_btns(3'b000);
      tick(30);
      bi.freeze = 1'b0;
    end

    // Bouncing right button settles into a clean hold.
    for (int i = 0; i < 20; i++) begin
      bi.right_raw = ((i % 4) < 2);
      tick(1);
    end
    k = cyc;
    bi.right_raw = 1'b1;
    expect_press(k, 3'b100, 0);
    tick(10);
    bi.right_raw = 1'b0;
    tick(30);

    // Presses landing inside freeze are lost, even when freeze drops mid-hold.
    bi.freeze = 1'b1;
    bi.enter_raw = 1'b1;
    tick(15);
    bi.freeze = 1'b0;
    tick(15);
    bi.enter_raw = 1'b0;
    tick(30);
    bi.freeze = 1'b1;
    bi.left_raw = 1'b1;
    tick(12);
    bi.freeze = 1'b0;
    tick(40);
    bi.left_raw = 1'b0;
    tick(30);
    k = cyc;
    bi.enter_raw = 1'b1;
    expect_press(k, 3'b001, 0);
    tick(10);
    bi.enter_raw = 1'b0;
    tick(30);

    // Reset lands on the first REPEAT pulse of a held left button.
    k = cyc;
    bi.left_raw = 1'b1;
    expect_press(k, 3'b010, 1);
    tick(34);
    @(posedge clk);
    #1;
    check("pulse_before_reset", outs(), 3'b010);
    reset = 1'b0;
    #1;
    check("async_reset_clears", outs(), 3'b000);
    tick(4);
    m = cyc;
    reset = 1'b1;
    expect_press(m, 3'b010, 2);
    tick(30);
    bi.left_raw = 1'b0;
    tick(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
